// File: rtl/i2c_eeprom_slave.sv
`timescale 1ns/1ps
// 24C02-class I2C EEPROM responder backed by a 2**ADDR_W x 8 on-chip array.
// Define EE_WP_EN to add the wp input, which NACKs and blocks data-byte writes.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'b1010_000,
  parameter int         ADDR_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] last_wr_data,
  output logic       wr_pulse,
  output logic       busy
`ifdef EE_WP_EN
  ,
  input  logic       wp
`endif
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          bitCnt_q, bitCnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                sdaOe_q, sdaOe_d;
  logic                busy_q, busy_d;
  logic [7:0]          lastWr_q, lastWr_d;
  logic                wrPulse_q, wrPulse_d;
  logic                nack_q, nack_d;

  logic                sclMeta_q, sclSync_q, sclPrev_q;
  logic                sdaMeta_q, sdaSync_q, sdaPrev_q;
  logic                sclRise, sclFall, startDet, stopDet, sdaBit, wpActive;

  logic [7:0]          mem_q [0:(1<<ADDR_W)-1];
  logic [7:0]          rdByte, newByte;
  logic                memWe;

  // Bus lines idle high, so the synchronizers reset to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclMeta_q <= scl;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
      sdaMeta_q <= sda;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaSync_q;
    end
  end

`ifdef EE_WP_EN
  logic wpMeta_q, wpSync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wpMeta_q <= 1'b0;
      wpSync_q <= 1'b0;
    end else begin
      wpMeta_q <= wp;
      wpSync_q <= wpMeta_q;
    end
  end

  assign wpActive = wpSync_q;
`else
  assign wpActive = 1'b0;
`endif

  assign sclRise  =  sclSync_q & ~sclPrev_q;
  assign sclFall  = ~sclSync_q &  sclPrev_q;
  assign startDet =  sclSync_q &  sdaPrev_q & ~sdaSync_q;
  assign stopDet  =  sclSync_q & ~sdaPrev_q &  sdaSync_q;
  assign sdaBit   =  sdaSync_q;
  assign rdByte   =  mem_q[ptr_q];
  assign newByte  =  {shift_q[6:0], sdaBit};

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sdaOe_d   = sdaOe_q;
    busy_d    = busy_q;
    lastWr_d  = lastWr_q;
    wrPulse_d = 1'b0;
    nack_d    = nack_q;
    memWe     = 1'b0;

    // START/STOP override every state; a partial byte is simply dropped.
    if (startDet) begin
      state_d  = DEV;
      bitCnt_d = 4'd0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
    end else if (stopDet) begin
      state_d  = IDLE;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sdaOe_d = 1'b0;
        end
        DEV: begin
          if (sclRise) begin
            shift_d  = newByte;
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == 4'd8) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d = DEV_ACK;
              sdaOe_d = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        // The fall that ends the ACK also drives bit 7 of a read byte.
        DEV_ACK: begin
          if (sclFall) begin
            if (shift_q[0]) begin
              state_d  = RDATA;
              shift_d  = {rdByte[6:0], 1'b0};
              sdaOe_d  = ~rdByte[7];
              bitCnt_d = 4'd1;
            end else begin
              state_d  = WADDR;
              sdaOe_d  = 1'b0;
              bitCnt_d = 4'd0;
            end
          end
        end
        WADDR: begin
          if (sclRise) begin
            shift_d  = newByte;
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall && bitCnt_q == 4'd8) begin
            ptr_d   = shift_q[ADDR_W-1:0];
            state_d = WADDR_ACK;
            sdaOe_d = 1'b1;
          end
        end
        WADDR_ACK, WDATA_ACK: begin
          if (sclFall) begin
            state_d  = WDATA;
            sdaOe_d  = 1'b0;
            bitCnt_d = 4'd0;
          end
        end
        WDATA: begin
          if (sclRise) begin
            shift_d  = newByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              nack_d = wpActive;
              if (!wpActive) begin
                memWe     = 1'b1;
                lastWr_d  = newByte;
                wrPulse_d = 1'b1;
                ptr_d     = ptr_q + ADDR_W'(1);
              end
            end
          end else if (sclFall && bitCnt_q == 4'd8) begin
            state_d = WDATA_ACK;
            sdaOe_d = ~nack_q;
          end
        end
        // bitCnt_q counts bits already driven; the 9th fall hands sda to the master.
        RDATA: begin
          if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              state_d  = RACK;
              sdaOe_d  = 1'b0;
              ptr_d    = ptr_q + ADDR_W'(1);
              bitCnt_d = 4'd0;
            end else begin
              sdaOe_d  = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              bitCnt_d = bitCnt_q + 4'd1;
            end
          end
        end
        RACK: begin
          if (sclRise) begin
            if (!sdaBit) begin
              state_d  = RDATA;
              shift_d  = rdByte;
              bitCnt_d = 4'd0;
            end else begin
              state_d  = IDLE;
              busy_d   = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      sdaOe_q   <= 1'b0;
      busy_q    <= 1'b0;
      lastWr_q  <= 8'h00;
      wrPulse_q <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sdaOe_q   <= sdaOe_d;
      busy_q    <= busy_d;
      lastWr_q  <= lastWr_d;
      wrPulse_q <= wrPulse_d;
      nack_q    <= nack_d;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[ptr_q] <= newByte;
    end
  end

  assign sda          = sdaOe_q ? 1'b0 : 1'bz;
  assign last_wr_data = lastWr_q;
  assign wr_pulse     = wrPulse_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
`timescale 1ns/1ps
// Directed bench for i2c_eeprom_slave: a bit-banged I2C master, a byte model of
// the array and a read-data scoreboard queue.
module tb_i2c_eeprom_slave;

  localparam int Q = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sdaLow;
  wire        sda;
  logic [7:0] last_wr_data;
  logic       wr_pulse;
  logic       busy;
`ifdef EE_WP_EN
  logic       wp;
`endif

  int         checkCount = 0;
  int         passCount  = 0;
  int         pulseCount = 0;
  logic [7:0] model [256];
  logic [7:0] expQ [$];
  logic [7:0] wrBuf [4];

  assign sda = sdaLow ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl          (scl),
    .sda          (sda),
    .last_wr_data (last_wr_data),
    .wr_pulse     (wr_pulse),
    .busy         (busy)
`ifdef EE_WP_EN
    ,
    .wp           (wp)
`endif
  );

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) pulseCount++;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: cycle budget expired, observed running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  task automatic writeBit(input logic b);
    waitQ();
    sdaLow = !b;
    waitQ();
    scl = 1'b1;
    waitQ();
    waitQ();
    scl = 1'b0;
  endtask

  task automatic readBit(output logic b);
    waitQ();
    sdaLow = 1'b0;
    waitQ();
    scl = 1'b1;
    waitQ();
    b = sda;
    waitQ();
    scl = 1'b0;
  endtask

  task automatic i2cStart();
    sdaLow = 1'b0;
    waitQ();
    scl = 1'b1;
    waitQ();
    sdaLow = 1'b1;
    waitQ();
    scl = 1'b0;
  endtask

  task automatic i2cStop();
    waitQ();
    sdaLow = 1'b1;
    waitQ();
    scl = 1'b1;
    waitQ();
    sdaLow = 1'b0;
    waitQ();
  endtask

  // Sends one byte MSB first and returns the slave's ACK bit (0 = ACK).
  task automatic applyStimulus(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(data[i]);
    readBit(ack);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] data);
    logic b;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      data = {data[6:0], b};
    end
    writeBit(!masterAck);
  endtask

  task automatic writeSeq(input logic [7:0] addr, input int n);
    logic       ack;
    logic [7:0] a;
    i2cStart();
    applyStimulus(8'hA0, ack);
    checkOutput("wr_dev_ack", ack, 0);
    checkOutput("wr_busy", busy, 1);
    applyStimulus(addr, ack);
    checkOutput("wr_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(wrBuf[i], ack);
      checkOutput("wr_data_ack", ack, 0);
      a = addr + 8'(i);
      model[a] = wrBuf[i];
    end
    i2cStop();
    checkOutput("wr_busy_stop", busy, 0);
  endtask

  task automatic randomRead(input logic [7:0] addr, input int n);
    logic       ack;
    logic [7:0] got;
    logic [7:0] a;
    i2cStart();
    applyStimulus(8'hA0, ack);
    checkOutput("rr_dev_ack", ack, 0);
    applyStimulus(addr, ack);
    checkOutput("rr_addr_ack", ack, 0);
    i2cStart();
    applyStimulus(8'hA1, ack);
    checkOutput("rr_rd_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      a = addr + 8'(i);
      expQ.push_back(model[a]);
    end
    for (int i = 0; i < n; i++) begin
      readByte(i < n - 1, got);
      checkOutput("rd_data", got, expQ.pop_front());
    end
    checkOutput("rd_sda_released", sda, 1);
    checkOutput("rd_busy_after_nack", busy, 0);
    i2cStop();
    checkOutput("rd_busy_stop", busy, 0);
  endtask

  initial begin
    int         p0;
    logic       ack;
    logic [7:0] got;
    logic [7:0] partial;

    rst_n  = 1'b0;
    scl    = 1'b1;
    sdaLow = 1'b0;
`ifdef EE_WP_EN
    wp     = 1'b0;
`endif
    repeat (5) @(negedge clk);
    checkOutput("rst_sda", sda, 1);
    checkOutput("rst_last_wr_data", last_wr_data, 8'h00);
    checkOutput("rst_wr_pulse", wr_pulse, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] byte write D1 -> 03");
    p0 = pulseCount;
    wrBuf[0] = 8'hD1;
    writeSeq(8'h03, 1);
    checkOutput("bw_pulses", pulseCount - p0, 1);
    checkOutput("bw_last", last_wr_data, 8'hD1);

    $display("[TB] random read 03");
    randomRead(8'h03, 1);

    $display("[TB] foreign header A2 then A0");
    i2cStart();
    applyStimulus(8'hA2, ack);
    checkOutput("a2_nack", ack, 1);
    checkOutput("a2_busy", busy, 0);
    i2cStop();
    i2cStart();
    applyStimulus(8'hA0, ack);
    checkOutput("a0_after_a2_ack", ack, 0);
    i2cStop();

    $display("[TB] sequential write/read across wrap");
    p0 = pulseCount;
    wrBuf[0] = 8'h11;
    wrBuf[1] = 8'h22;
    wrBuf[2] = 8'h33;
    writeSeq(8'hFE, 3);
    checkOutput("sw_pulses", pulseCount - p0, 3);
    checkOutput("sw_last", last_wr_data, 8'h33);
    randomRead(8'hFE, 3);
    randomRead(8'h00, 1);

    $display("[TB] START mid-byte aborts write");
    wrBuf[0] = 8'h5A;
    writeSeq(8'h20, 1);
    p0 = pulseCount;
    i2cStart();
    applyStimulus(8'hA0, ack);
    checkOutput("ab_dev_ack", ack, 0);
    applyStimulus(8'h20, ack);
    checkOutput("ab_addr_ack", ack, 0);
    partial = 8'hC3;
    for (int i = 7; i >= 4; i--) writeBit(partial[i]);
    i2cStart();
    applyStimulus(8'hA1, ack);
    checkOutput("ab_rd_ack", ack, 0);
    expQ.push_back(model[8'h20]);
    readByte(1'b0, got);
    checkOutput("ab_rd_data", got, expQ.pop_front());
    i2cStop();
    checkOutput("ab_pulses", pulseCount - p0, 0);
    checkOutput("ab_last", last_wr_data, 8'h5A);

`ifdef EE_WP_EN
    $display("[TB] write protect");
    wrBuf[0] = 8'h66;
    writeSeq(8'h10, 1);
    wp = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulseCount;
    i2cStart();
    applyStimulus(8'hA0, ack);
    checkOutput("wp_dev_ack", ack, 0);
    applyStimulus(8'h10, ack);
    checkOutput("wp_addr_ack", ack, 0);
    applyStimulus(8'h55, ack);
    checkOutput("wp_data_nack", ack, 1);
    i2cStop();
    checkOutput("wp_pulses", pulseCount - p0, 0);
    checkOutput("wp_last", last_wr_data, 8'h66);
    wp = 1'b0;
    randomRead(8'h10, 1);
`endif

    $display("[TB] async reset while slave drives ACK");
    i2cStart();
    partial = 8'hA0;
    for (int i = 7; i >= 0; i--) writeBit(partial[i]);
    waitQ();
    sdaLow = 1'b0;
    checkOutput("ar_ack_driven", sda, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("ar_sda_released", sda, 1);
    checkOutput("ar_busy", busy, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    scl   = 1'b1;
    repeat (10) @(negedge clk);

    checkOutput("sb_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
